// File: rtl/moore_sequencer.sv
// moore_sequencer: debounced start/mode buttons drive a Moore LED shift/bounce sequencer with pause.
module moore_sequencer #(
  parameter int N_LEDS     = 8,
  parameter int DB_SAMPLES = 3
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              tick_mf,
  input  logic              tick_lf,
  input  logic              btn_start,
  input  logic              btn_mode,
  input  logic              dir,
  output logic [N_LEDS-1:0] leds,
  output logic [1:0]        state_out,
  output logic [7:0]        step_count
);
  typedef enum logic [1:0] {IDLE, SHIFT, BOUNCE, PAUSE} state_t;
  logic [1:0] sync1_q, sync2_q, stable_q, prev_q, press;
  logic [DB_SAMPLES-1:0] hist_q [2];
  logic [DB_SAMPLES-1:0] hist_d [2];
  state_t state_q, state_d, run_q, run_d;
  logic [N_LEDS-1:0] leds_q, leds_d, rot, bnc;
  logic [7:0] cnt_q, cnt_d;
  logic up_q, up_d, eff_up;
  always_comb
    for (int i = 0; i < 2; i++) hist_d[i] = DB_SAMPLES'({hist_q[i], sync2_q[i]});
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      prev_q    <= '0;
      hist_q[0] <= '0;
      hist_q[1] <= '0;
    end else begin
      sync1_q <= {btn_mode, btn_start};
      sync2_q <= sync1_q;
      prev_q  <= stable_q;
      if (tick_mf)
        for (int i = 0; i < 2; i++) begin
          hist_q[i] <= hist_d[i];
          if (&hist_d[i]) stable_q[i] <= 1'b1;
          else if (~|hist_d[i]) stable_q[i] <= 1'b0;
        end
    end
  assign press = stable_q & ~prev_q;
  // Bounce turns around on the spot when the heading points off the end of the bar.
  assign eff_up = up_q ? ~leds_q[N_LEDS-1] : leds_q[0];
  assign bnc    = eff_up ? leds_q << 1 : leds_q >> 1;
  assign rot    = dir ? {leds_q[0], leds_q[N_LEDS-1:1]} : {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    leds_d  = leds_q;
    cnt_d   = cnt_q;
    up_d    = up_q;
    case (state_q)
      IDLE: begin
        leds_d = '0;
        cnt_d  = '0;
        up_d   = 1'b1;
        if (press[0]) begin
          state_d = SHIFT;
          leds_d  = N_LEDS'(1);
        end
      end
      SHIFT, BOUNCE: begin
        if (press[0]) begin
          state_d = PAUSE;
          run_d   = state_q;
        end else if (press[1]) begin
          state_d = (state_q == SHIFT) ? BOUNCE : SHIFT;
          up_d    = (state_q == SHIFT) ? 1'b1 : up_q;
        end else if (tick_lf) begin
          leds_d = (state_q == SHIFT) ? rot : bnc;
          up_d   = (state_q == SHIFT) ? up_q : (eff_up ? ~bnc[N_LEDS-1] : bnc[0]);
          cnt_d  = cnt_q + 8'd1;
        end
      end
      PAUSE: begin
        if (press[0]) state_d = run_q;
        else if (press[1]) begin
          state_d = IDLE;
          leds_d  = '0;
          cnt_d   = '0;
          up_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        leds_d  = '0;
        cnt_d   = '0;
        up_d    = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      run_q   <= SHIFT;
      leds_q  <= '0;
      cnt_q   <= '0;
      up_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      leds_q  <= leds_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
    end
  assign leds       = leds_q;
  assign state_out  = state_q;
  assign step_count = cnt_q;
endmodule

// File: doc/moore_sequencer.md
MOORE_SEQUENCER -- requirements
Module: moore_sequencer

Interface
REQ-001 Parameter N_LEDS, default 8, width of LED pattern; SHALL be in the range 4..32.
REQ-002 Parameter DB_SAMPLES, default 3, number of consecutive equal tick_mf samples needed to accept a button level.
REQ-003 clk_in  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 tick_mf  input  1  one-cycle strobe from freq_divider; button sampling rate.
REQ-006 tick_lf  input  1  one-cycle strobe from freq_divider; sequence step rate.
REQ-007 btn_start  input  1  raw asynchronous start/pause button, active-high.
REQ-008 btn_mode  input  1  raw asynchronous mode button, active-high.
REQ-009 dir  input  1  SHIFT direction: 0 moves toward MSB, 1 moves toward LSB; SHALL be sampled only on a step.
REQ-010 leds  output  N_LEDS  registered LED pattern.
REQ-011 state_out  output  2  registered state code: IDLE=0, SHIFT=1, BOUNCE=2, PAUSE=3.
REQ-012 step_count  output  8  registered count of steps taken since leaving IDLE.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer on clk_in before debounce.
REQ-014 Debounce: on each tick_mf, the synchronized level SHALL shift into a DB_SAMPLES-deep history; the stable level SHALL update only when all samples agree.
REQ-015 A press event SHALL be a one-cycle pulse on a stable 0->1 transition; release and bounce SHALL generate no event.
REQ-016 FSM SHALL be Moore: leds, state_out and step_count SHALL depend only on registered state.
REQ-017 The FSM SHALL register a state change on the clk_in edge after the cycle in which the press pulse is high.
REQ-018 IDLE: leds=0, step_count=0; a start press SHALL transition to SHIFT with leds=1 (bit 0 set).
REQ-019 SHIFT: each tick_lf SHALL rotate leds one position per dir, wrapping MSB->bit 0 (dir=0) and bit 0->MSB (dir=1).
REQ-020 SHIFT: a mode press SHALL transition to BOUNCE, keep the current position, and set the bounce heading toward the MSB.
REQ-021 BOUNCE: each tick_lf SHALL move the lit bit one position along the heading; on reaching bit N_LEDS-1 the heading SHALL flip to down, and on reaching bit 0 it SHALL flip to up. There SHALL be no wrap, so the sequence is 0,1,..,N-1,N-2,..,0,1.
REQ-022 BOUNCE: dir SHALL be ignored; a mode press SHALL transition to SHIFT, keeping the position.
REQ-023 SHIFT or BOUNCE: a start press SHALL transition to PAUSE and record the run state.
REQ-024 PAUSE: leds, heading and step_count SHALL hold; a start press SHALL resume the recorded run state; a mode press SHALL return to IDLE.
REQ-025 Every step in SHIFT or BOUNCE SHALL increment step_count modulo 256 (255->0); a step SHALL occur only on tick_lf.
REQ-026 If tick_lf and a press occur in the same cycle, the press SHALL be processed and the step SHALL be dropped.
REQ-027 If start and mode presses occur in the same cycle, the start press SHALL be processed and the mode press SHALL be ignored.
REQ-028 In SHIFT, BOUNCE and PAUSE, leds SHALL be one-hot at all times.
REQ-029 Unreachable state encodings SHALL recover to IDLE on the next clock.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, leds=0, state_out=0, step_count=0, heading up, synchronizers, histories and stable levels 0, and no pending press.
REQ-031 Reset asserted mid-sequence SHALL abandon the sequence; after release, the first start press SHALL restart from leds=1.

Verification
REQ-032 Reset, clean start press held longer than 3 tick_mf, then 3 tick_lf with dir=0 (N=8) -> leds 0x01 then 0x02, 0x04, 0x08; state_out=1; step_count=3.
REQ-033 SHIFT at 0x80 with dir=0, then one tick_lf -> leds 0x01; with dir=1 at 0x01, one tick_lf -> 0x80.
REQ-034 Mode press at 0x20, then 4 tick_lf -> state_out=2; leds 0x40, 0x80, 0x40, 0x20.
REQ-035 Start toggling 0/1 every tick_mf for 10 ticks -> no state change; then press start -> PAUSE holds leds through 5 tick_lf; press start again -> previous run state resumes.
REQ-036 Press and tick_lf in the same cycle -> no step, and step_count is unchanged. Simultaneous start and mode presses in SHIFT -> PAUSE.
REQ-037 rst_n pulsed low mid-BOUNCE, asynchronously to clk_in -> all outputs 0 within the same cycle; 256 steps after restart -> step_count wraps to 0.
